// File: rtl/javk_pkg.sv
// rtl/javk_pkg.sv - shared encodings for the JAVK execute/decode slice
package javk_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_ROR = 3'd7
    } alu_op_e;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDL   = 4'h1;
    localparam logic [3:0] OP_LDH   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_ROR   = 4'hA;
    localparam logic [3:0] OP_LD    = 4'hB;
    localparam logic [3:0] OP_ST    = 4'hC;
    localparam logic [3:0] OP_MOV16 = 4'hD;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] REG16_IJ = 2'd0;
    localparam logic [1:0] REG16_PC = 2'd1;
    localparam logic [1:0] REG16_SP = 2'd2;
    localparam logic [1:0] REG16_XY = 2'd3;

endpackage

// File: rtl/javk_alu_core.sv
// rtl/javk_alu_core.sv - 8-bit ALU datapath with registered result and NZCV flags
module javk_alu_core
    import javk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [2:0] op_i,
    input  logic [3:0] shamt_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] alu_out_o,
    output logic [3:0] flags_o
);

    logic [7:0] alu_out_q, alu_out_d;
    logic [3:0] flags_q, flags_d;
    logic [8:0] sum;
    logic [8:0] diff;
    logic       c_d;
    logic       v_d;
    logic       in_range;

    assign sum      = {1'b0, a_i} + {1'b0, b_i};
    assign diff     = {1'b0, a_i} - {1'b0, b_i};
    // Carry exists only when the shift actually moves a bit out of the byte.
    assign in_range = (shamt_i != 4'd0) && (shamt_i <= 4'd8);

    always_comb begin
        alu_out_d = 8'h00;
        c_d       = 1'b0;
        v_d       = 1'b0;
        case (alu_op_e'(op_i))
            ALU_ADD: begin
                alu_out_d = sum[7:0];
                c_d       = sum[8];
                v_d       = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
            end
            ALU_SUB: begin
                alu_out_d = diff[7:0];
                c_d       = diff[8];
                v_d       = (a_i[7] != b_i[7]) && (diff[7] != a_i[7]);
            end
            ALU_AND: alu_out_d = a_i & b_i;
            ALU_OR:  alu_out_d = a_i | b_i;
            ALU_XOR: alu_out_d = a_i ^ b_i;
            ALU_SHL: begin
                alu_out_d = shamt_i[3] ? 8'h00 : (a_i << shamt_i[2:0]);
                c_d       = in_range && a_i[3'(4'd8 - shamt_i)];
            end
            ALU_SHR: begin
                alu_out_d = shamt_i[3] ? 8'h00 : (a_i >> shamt_i[2:0]);
                c_d       = in_range && a_i[3'(shamt_i - 4'd1)];
            end
            ALU_ROR: begin
                alu_out_d = (a_i >> shamt_i[2:0]) | (a_i << (4'd8 - {1'b0, shamt_i[2:0]}));
                c_d       = alu_out_d[7];
            end
            default: alu_out_d = 8'h00;
        endcase
        flags_d         = 4'b0000;
        flags_d[FLAG_N] = alu_out_d[7];
        flags_d[FLAG_Z] = (alu_out_d == 8'h00);
        flags_d[FLAG_C] = c_d;
        flags_d[FLAG_V] = v_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= 8'h00;
            flags_q   <= 4'b0000;
        end else if (en_i) begin
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
        end
    end

    assign alu_out_o = alu_out_q;
    assign flags_o   = flags_q;

endmodule

// File: rtl/javk_alu_ctrl.sv
// rtl/javk_alu_ctrl.sv - JAVK instruction register, strobe decoder and ALU wrapper
module javk_alu_ctrl
    import javk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] alu_out,
    output logic [3:0] flags,
    output logic [2:0] alu_op,
    output logic [3:0] alu_shamt,
    output logic       alu_clk,
    output logic [3:0] addr_offset,
    output logic       fetch,
    output logic       we,
    output logic       nibble_read,
    output logic       nibble_hl,
    output logic [3:0] nibble_out,
    output logic [3:0] reg_sel,
    output logic [1:0] reg16_src,
    output logic [1:0] reg16_dst
);

    logic [7:0] instr_q;
    logic [3:0] opc;
    logic [3:0] fld;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= {OP_NOP, 4'h0};
        end else begin
            instr_q <= instr;
        end
    end

    assign opc = instr_q[7:4];
    assign fld = instr_q[3:0];

    always_comb begin
        alu_op      = ALU_ADD;
        alu_shamt   = 4'h0;
        alu_clk     = 1'b0;
        addr_offset = 4'h0;
        fetch       = 1'b0;
        we          = 1'b0;
        nibble_read = 1'b0;
        nibble_hl   = 1'b0;
        nibble_out  = 4'h0;
        reg_sel     = 4'h0;
        reg16_src   = REG16_IJ;
        reg16_dst   = REG16_IJ;
        case (opc)
            OP_LDL: begin
                nibble_read = 1'b1;
                nibble_out  = fld;
            end
            OP_LDH: begin
                nibble_read = 1'b1;
                nibble_hl   = 1'b1;
                nibble_out  = fld;
            end
            OP_ADD: begin alu_clk = 1'b1; reg_sel = fld; alu_op = ALU_ADD; end
            OP_SUB: begin alu_clk = 1'b1; reg_sel = fld; alu_op = ALU_SUB; end
            OP_AND: begin alu_clk = 1'b1; reg_sel = fld; alu_op = ALU_AND; end
            OP_OR:  begin alu_clk = 1'b1; reg_sel = fld; alu_op = ALU_OR;  end
            OP_XOR: begin alu_clk = 1'b1; reg_sel = fld; alu_op = ALU_XOR; end
            OP_SHL: begin alu_clk = 1'b1; alu_shamt = fld; alu_op = ALU_SHL; end
            OP_SHR: begin alu_clk = 1'b1; alu_shamt = fld; alu_op = ALU_SHR; end
            OP_ROR: begin alu_clk = 1'b1; alu_shamt = fld; alu_op = ALU_ROR; end
            OP_LD: begin
                fetch       = 1'b1;
                addr_offset = fld;
            end
            OP_ST: begin
                fetch       = 1'b1;
                we          = 1'b1;
                addr_offset = fld;
            end
            OP_MOV16: begin
                reg16_dst = fld[3:2];
                reg16_src = fld[1:0];
            end
            default: alu_clk = 1'b0;
        endcase
    end

    javk_alu_core u_alu (
        .clk       (clk),
        .rst       (rst),
        .en_i      (alu_clk),
        .op_i      (alu_op),
        .shamt_i   (alu_shamt),
        .a_i       (a),
        .b_i       (b),
        .alu_out_o (alu_out),
        .flags_o   (flags)
    );

endmodule

// File: tb/tb_javk_alu_ctrl.sv
// tb/tb_javk_alu_ctrl.sv - self-checking bench for javk_alu_ctrl
module tb_javk_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr, a, b;
    logic [7:0] alu_out;
    logic [3:0] flags;
    logic [2:0] alu_op;
    logic [3:0] alu_shamt, addr_offset, nibble_out, reg_sel;
    logic       alu_clk, fetch, we, nibble_read, nibble_hl;
    logic [1:0] reg16_src, reg16_dst;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    javk_alu_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .a(a), .b(b),
        .alu_out(alu_out), .flags(flags), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_clk(alu_clk), .addr_offset(addr_offset), .fetch(fetch), .we(we),
        .nibble_read(nibble_read), .nibble_hl(nibble_hl), .nibble_out(nibble_out),
        .reg_sel(reg_sel), .reg16_src(reg16_src), .reg16_dst(reg16_dst)
    );

    // {alu_op, shamt, alu_clk, offset, fetch, we, nr, nhl, nout, reg_sel, src, dst}
    function automatic logic [27:0] dec_vec();
        return {alu_op, alu_shamt, alu_clk, addr_offset, fetch, we, nibble_read,
                nibble_hl, nibble_out, reg_sel, reg16_src, reg16_dst};
    endfunction

    function automatic logic [27:0] dec_ref(input logic [7:0] ins);
        logic [3:0] op, f;
        logic [2:0] r_op;
        logic [3:0] r_sh, r_off, r_nout, r_sel;
        logic       r_clk, r_fetch, r_we, r_nr, r_nhl;
        logic [1:0] r_src, r_dst;
        op = ins[7:4];
        f  = ins[3:0];
        {r_op, r_sh, r_clk, r_off, r_fetch, r_we, r_nr, r_nhl, r_nout, r_sel, r_src, r_dst} = '0;
        if (op >= 4'h3 && op <= 4'h7) begin
            r_clk = 1; r_sel = f; r_op = 3'(op - 4'h3);
        end else if (op >= 4'h8 && op <= 4'hA) begin
            r_clk = 1; r_sh = f; r_op = 3'(op - 4'h3);
        end else if (op == 4'h1 || op == 4'h2) begin
            r_nr = 1; r_nhl = (op == 4'h2); r_nout = f;
        end else if (op == 4'hB || op == 4'hC) begin
            r_fetch = 1; r_we = (op == 4'hC); r_off = f;
        end else if (op == 4'hD) begin
            r_dst = f[3:2]; r_src = f[1:0];
        end
        return {r_op, r_sh, r_clk, r_off, r_fetch, r_we, r_nr, r_nhl, r_nout, r_sel, r_src, r_dst};
    endfunction

    // Returns {flags, result}
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [3:0] s,
                                            input logic [7:0] x, input logic [7:0] y);
        int          sx, sy, sr;
        logic [7:0]  r;
        logic        c, v;
        sx = $signed(x);
        sy = $signed(y);
        c = 0; v = 0; r = 0;
        case (op)
            3'd0: begin
                r = 8'(int'(x) + int'(y)); c = (int'(x) + int'(y)) > 255;
                sr = sx + sy; v = (sr > 127) || (sr < -128);
            end
            3'd1: begin
                r = 8'(int'(x) - int'(y)); c = x < y;
                sr = sx - sy; v = (sr > 127) || (sr < -128);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin r = x; for (int i = 0; i < int'(s); i++) begin c = r[7]; r = {r[6:0], 1'b0}; end end
            3'd6: begin r = x; for (int i = 0; i < int'(s); i++) begin c = r[0]; r = {1'b0, r[7:1]}; end end
            default: begin
                r = x;
                for (int i = 0; i < int'(s) % 8; i++) r = {r[0], r[7:1]};
                c = r[7];
            end
        endcase
        return {r[7], r == 8'h00, c, v, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; instr = 8'h00; a = 8'h00; b = 8'h00;
        tick();
        total++; if (dec_vec() !== 28'h0) $display("FAIL reset_strobes got=%h want=0", dec_vec()); else passed++;
        total++; if ({alu_out, flags} !== 12'h000) $display("FAIL reset_alu got=%h/%b want=00/0000", alu_out, flags); else passed++;
        instr = 8'h35; a = 8'h7F; b = 8'h01;
        tick();
        total++; if (alu_clk !== 1'b0) $display("FAIL reset_discard_instr alu_clk=%b want=0", alu_clk); else passed++;
        rst = 0;
        tick();
        rst = 1; instr = 8'h00;
        tick();
        total++; if ({alu_out, flags} !== 12'h000) $display("FAIL reset_discard_alu got=%h/%b want=00/0000", alu_out, flags); else passed++;
        rst = 0;
        tick();
    endtask

    task automatic test_add();
        instr = 8'h35; a = 8'h7F; b = 8'h01;
        tick();
        total++; if (reg_sel !== 4'd5) $display("FAIL add_reg_sel got=%0d want=5", reg_sel); else passed++;
        total++; if (alu_op !== 3'd0) $display("FAIL add_alu_op got=%0d want=0", alu_op); else passed++;
        total++; if (alu_clk !== 1'b1) $display("FAIL add_alu_clk got=%b want=1", alu_clk); else passed++;
        instr = 8'h00;
        tick();
        total++; if ({alu_out, flags} !== {8'h80, 4'b1001}) $display("FAIL add_result got=%h/%b want=80/1001", alu_out, flags); else passed++;
    endtask

    task automatic test_sub();
        instr = 8'h42; a = 8'h00; b = 8'h01;
        tick();
        instr = 8'h00;
        tick();
        total++; if ({alu_out, flags} !== {8'hFF, 4'b1010}) $display("FAIL sub_result got=%h/%b want=FF/1010", alu_out, flags); else passed++;
    endtask

    task automatic test_shifts();
        a = 8'h0C; b = 8'h55;
        instr = 8'h93; tick(); instr = 8'h00; tick();
        total++; if ({alu_out, flags} !== {8'h01, 4'b0010}) $display("FAIL shr3 got=%h/%b want=01/0010", alu_out, flags); else passed++;
        instr = 8'h89; tick(); instr = 8'h00; tick();
        total++; if ({alu_out, flags} !== {8'h00, 4'b0100}) $display("FAIL shl9 got=%h/%b want=00/0100", alu_out, flags); else passed++;
        instr = 8'h88; a = 8'h01; tick(); instr = 8'h00; tick();
        total++; if ({alu_out, flags} !== {8'h00, 4'b0110}) $display("FAIL shl8 got=%h/%b want=00/0110", alu_out, flags); else passed++;
        instr = 8'hA1; a = 8'h01; tick(); instr = 8'h00; tick();
        total++; if ({alu_out, flags} !== {8'h80, 4'b1010}) $display("FAIL ror1 got=%h/%b want=80/1010", alu_out, flags); else passed++;
    endtask

    task automatic test_nonalu();
        instr = 8'h35; a = 8'h12; b = 8'h34; tick(); instr = 8'h00; tick();
        total++; if ({alu_out, flags} !== {8'h46, 4'b0000}) $display("FAIL add_plain got=%h/%b want=46/0000", alu_out, flags); else passed++;
        instr = 8'hC7; a = 8'hFF; b = 8'hFF;
        tick();
        total++; if ({fetch, we, addr_offset} !== {1'b1, 1'b1, 4'd7}) $display("FAIL st_strobes got=%b%b%h want=117", fetch, we, addr_offset); else passed++;
        total++; if (alu_clk !== 1'b0) $display("FAIL st_alu_clk got=%b want=0", alu_clk); else passed++;
        instr = 8'h1A;
        tick();
        total++; if ({nibble_read, nibble_hl, nibble_out} !== {1'b1, 1'b0, 4'hA}) $display("FAIL ldl_strobes got=%b%b%h want=10A", nibble_read, nibble_hl, nibble_out); else passed++;
        total++; if (fetch !== 1'b0) $display("FAIL ldl_fetch got=%b want=0", fetch); else passed++;
        instr = 8'h00;
        tick();
        total++; if ({alu_out, flags} !== {8'h46, 4'b0000}) $display("FAIL nonalu_hold got=%h/%b want=46/0000", alu_out, flags); else passed++;
    endtask

    task automatic test_mov_nop();
        instr = 8'hD9;
        tick();
        total++; if ({reg16_dst, reg16_src} !== {2'd2, 2'd1}) $display("FAIL mov16_fields got=%0d/%0d want=2/1", reg16_dst, reg16_src); else passed++;
        total++; if (dec_vec() !== 28'h6) $display("FAIL mov16_vec got=%h want=0000006", dec_vec()); else passed++;
        instr = 8'hF3;
        tick();
        total++; if (dec_vec() !== 28'h0) $display("FAIL nop_vec got=%h want=0", dec_vec()); else passed++;
        total++; if ({alu_out, flags} !== {8'h46, 4'b0000}) $display("FAIL nop_hold got=%h/%b want=46/0000", alu_out, flags); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  m_instr_q, m_out;
        logic [3:0]  m_flags;
        logic [27:0] d;
        logic [11:0] r;
        rst = 1; instr = 8'h00;
        tick();
        rst = 0;
        m_instr_q = 8'h00; m_out = 8'h00; m_flags = 4'h0;
        for (int n = 0; n < 500; n++) begin
            instr = 8'($urandom);
            a     = 8'($urandom);
            b     = 8'($urandom);
            @(posedge clk);
            d = dec_ref(m_instr_q);
            if (d[20]) begin
                r = alu_ref(d[27:25], d[24:21], a, b);
                m_flags = r[11:8];
                m_out   = r[7:0];
            end
            m_instr_q = instr;
            #1;
            total++; if (dec_vec() !== dec_ref(m_instr_q)) $display("FAIL b2b_decode n=%0d instr=%h got=%h want=%h", n, m_instr_q, dec_vec(), dec_ref(m_instr_q)); else passed++;
            total++; if (alu_out !== m_out) $display("FAIL b2b_alu_out n=%0d got=%h want=%h", n, alu_out, m_out); else passed++;
            total++; if (flags !== m_flags) $display("FAIL b2b_flags n=%0d got=%b want=%b", n, flags, m_flags); else passed++;
        end
    endtask

    initial begin
        rst = 1; instr = 8'h00; a = 8'h00; b = 8'h00;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_shifts();
        test_nonalu();
        test_mov_nop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/javk_alu_ctrl.md
# javk_alu_ctrl

Execute/decode slice of the JAVK 8-bit CPU. It registers the current instruction byte and decodes it into datapath strobes: nibble loads, memory fetch and store, 16-bit register moves, and register-file select. It also contains the 8-bit ALU, which produces the accumulator result and NZCV flags. It sits between the fetch logic (which supplies `instr`) and the register file and bus unit (which consume the strobes and supply the operands).

## Interface
Parameters: none.
- `clk`  in  1  single system clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `instr`  in  8  instruction byte to decode
- `a`  in  8  accumulator (register A) value
- `b`  in  8  second operand, the register selected by `reg_sel`
- `alu_out`  out  8  registered ALU result
- `flags`  out  4  registered flags {N,Z,C,V} (bit3..bit0)
- `alu_op`  out  3  decoded ALU operation
- `alu_shamt`  out  4  shift/rotate amount
- `alu_clk`  out  1  ALU update strobe; also the internal ALU enable
- `addr_offset`  out  4  offset added to {I,J} for a memory access
- `fetch`  out  1  memory access this cycle
- `we`  out  1  the access is a store (1) or a load (0)
- `nibble_read`  out  1  load immediate nibble into A
- `nibble_hl`  out  1  1 = A[7:4], 0 = A[3:0]
- `nibble_out`  out  4  immediate nibble
- `reg_sel`  out  4  register-file index for `b`
- `reg16_src`, `reg16_dst`  out  2 each  16-bit register pair codes: 0 IJ, 1 PC, 2 SP, 3 XY

## Operation
The opcode is `instr[7:4]`; the field `f` is `instr[3:0]`.
- `0x0`, `0xE`, `0xF`: NOP. All strobes are 0.
- `0x1` LDL: `nibble_read`=1, `nibble_hl`=0, `nibble_out`=f.
- `0x2` LDH: same as LDL but `nibble_hl`=1.
- `0x3`–`0x7` (ADD, SUB, AND, OR, XOR with register f):
  - `alu_clk`=1 and `reg_sel`=f.
  - `alu_op` is 0–4 respectively.
- `0x8` SHL f, `0x9` SHR f (logical), `0xA` ROR f:
  - `alu_clk`=1 and `alu_shamt`=f.
  - `alu_op` is 5, 6, 7 respectively.
- `0xB` LD: `fetch`=1, `we`=0, `addr_offset`=f.
- `0xC` ST: `fetch`=1, `we`=1, `addr_offset`=f.
- `0xD` MOV16: `reg16_dst`=f[3:2], `reg16_src`=f[1:0].

Default rule: every field output is 0 unless its instruction class drives it.

ALU arithmetic (8-bit, results truncated):
- ADD: C = carry out; V = signed overflow.
- SUB (a−b): C = borrow (a<b unsigned); V = signed overflow.
- AND, OR, XOR: C=0, V=0.
- SHL and SHR:
  - Shamt 0 passes `a` through with C=0.
  - Shamt 1–8: C = the last bit shifted out.
  - Shamt ≥8 gives a result of 0; shamt ≥9 gives C=0.
  - V=0.
- ROR: rotate right by shamt mod 8; C = result[7]; V=0.
- All ops: N = result[7]; Z = (result==0).

## Timing
- `instr` is captured into `instr_q` at a rising edge. All decode outputs are combinational from `instr_q`, so they are valid one cycle after `instr` is presented.
- When `alu_clk`=1, `alu_out` and `flags` load at the next rising edge from the current `a` and `b`. Result latency is 2 cycles from `instr`.
- When `alu_clk`=0, `alu_out` and `flags` hold their values. Non-ALU instructions never alter them.
- Reset state: `instr_q`=0x00 (NOP), so every strobe and field is 0. `alu_out`=0x00 and `flags`=4'b0000.
- `rst` takes priority over everything:
  - An instruction presented on the reset edge is discarded.
  - An ALU update pending on the reset edge is discarded.
- Back-to-back instructions are allowed: one instruction per cycle, with no stalls or handshake.

## Structure
- Shared package `javk_pkg`:
  - ALU op encodings (ADD=0 … ROR=7).
  - Opcode nibble constants.
  - Flag bit positions (N=3, Z=2, C=1, V=0).
  - reg16 pair codes.
- One sub-module, `javk_alu_core`, containing the ALU datapath and the result/flag registers, enabled by `alu_clk`.
- The decoder stays in the top level.

## Test plan
- Assert `rst` for 1 cycle → all strobes 0, `alu_out`=0x00, `flags`=0000. Then apply `0x35` with `rst` held → `alu_clk` stays 0.
- `instr`=0x35, `a`=0x7F, `b`=0x01:
  - +1 cycle: `reg_sel`=5, `alu_op`=0, `alu_clk`=1.
  - +2 cycles: `alu_out`=0x80, `flags`=1001.
- `instr`=0x42, `a`=0x00, `b`=0x01 → `alu_out`=0xFF, `flags`=1010.
- Shifts, `a`=0x0C:
  - `0x93` → `alu_out`=0x01, `flags`=0010.
  - `0x89` → `alu_out`=0x00, `flags`=0100.
- `instr`=0xC7 → `fetch`=1, `we`=1, `addr_offset`=7. Then `0x1A` → `nibble_read`=1, `nibble_hl`=0, `nibble_out`=0xA. `alu_out` and `flags` are unchanged throughout.
- `instr`=0xD9 → `reg16_dst`=2, `reg16_src`=1, all other strobes 0. Then `0xF3` → all outputs 0.
